// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP check arbiter: access kinds, error record,
// arbiter FSM states and the default-configuration request bundle.
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;

    // Error record as reported by the transaction checker.
    typedef struct packed {
        logic          error_detected;
        logic [2:0]    etype;
        logic [7:0]    sid;
        logic [63:0]   addr;
        access_t       access;
    } error_capture_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Request bundle for the default parameter set (64-bit addr, 64-bit data).
    localparam int ARB_ADDR_W = 64;
    localparam int ARB_NB_W   = 4;
    localparam int ARB_SID_W  = 8;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_NB_W-1:0]   num_bytes;
        logic [ARB_SID_W-1:0]  sid;
        access_t               access;
    } arb_req_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i.
module rv_iopmp_rr_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to ptr_i so the nearest valid wins.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (valid_i[cand]) begin
                gnt_idx_o = cand;
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_iopmp_check_arbiter.sv
// Shares one IOPMP transaction checker between NUMBER_REQ requesters.
// Round-robin grant, one transaction in flight, verdict routed back to the
// winner, first reported error held until cleared.
// Optional: RV_IOPMP_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES
// that answers with a deny when the checker never responds.
module rv_iopmp_check_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_WIDTH      = 8,
    parameter int NUMBER_REQ     = 2,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int NB_W          = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUMBER_REQ-1:0]                 req_valid_i,
    output logic [NUMBER_REQ-1:0]                 req_ready_o,
    input  logic [NUMBER_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUMBER_REQ-1:0][NB_W-1:0]       req_num_bytes_i,
    input  logic [NUMBER_REQ-1:0][SID_WIDTH-1:0]  req_sid_i,
    input  access_t [NUMBER_REQ-1:0]              req_access_i,
    output logic [NUMBER_REQ-1:0]                 rsp_valid_o,
    input  logic [NUMBER_REQ-1:0]                 rsp_ready_i,
    output logic                                  rsp_allow_o,
    output logic                                  chk_en_o,
    output logic [ADDR_WIDTH-1:0]                 chk_addr_o,
    output logic [NB_W-1:0]                       chk_num_bytes_o,
    output logic [SID_WIDTH-1:0]                  chk_sid_o,
    output access_t                               chk_access_o,
    input  logic                                  chk_ready_i,
    input  logic                                  chk_valid_i,
    input  logic                                  chk_allow_i,
    input  error_capture_t                        chk_err_i,
    output error_capture_t                        err_o,
    input  logic                                  err_clear_i
);

    localparam int IDX_W = idx_width(NUMBER_REQ);

    if (NUMBER_REQ < 1) begin : g_bad_num_req
        $error("NUMBER_REQ must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, gnt_q, gnt_idx, ptr_next;
    logic             any_vld, grant, chk_fire, timeout_hit, err_capture;

    rv_iopmp_rr_arbiter #(
        .N     (NUMBER_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .valid_i   (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_vld)
    );

    assign grant    = (state_q == IDLE) && any_vld && chk_ready_i;
    // Verdicts are only meaningful while a transaction is outstanding.
    assign chk_fire = (state_q == WAIT) && chk_valid_i;
    assign ptr_next = (gnt_idx == IDX_W'(NUMBER_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef RV_IOPMP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    assign timeout_hit = (state_q == WAIT) && !chk_valid_i &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on the way into WAIT, counts WAIT cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and the grant-cycle ready pulse.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    state_d              = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  if (chk_valid_i || timeout_hit) state_d = RESP;
            RESP:  if (rsp_ready_i[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response valid goes only to the requester that owns the transaction.
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == RESP) rsp_valid_o[gnt_q] = 1'b1;
    end

    assign chk_en_o = (state_q == ISSUE);

    // Capture winner, pointer and operands at grant; held until back in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q           <= '0;
            gnt_q           <= '0;
            chk_addr_o      <= '0;
            chk_num_bytes_o <= '0;
            chk_sid_o       <= '0;
            chk_access_o    <= ACCESS_NONE;
        end else if (grant) begin
            ptr_q           <= ptr_next;
            gnt_q           <= gnt_idx;
            chk_addr_o      <= req_addr_i[gnt_idx];
            chk_num_bytes_o <= req_num_bytes_i[gnt_idx];
            chk_sid_o       <= req_sid_i[gnt_idx];
            chk_access_o    <= req_access_i[gnt_idx];
        end
    end

    // Verdict register; a watchdog expiry answers with a deny.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          rsp_allow_o <= 1'b0;
        else if (chk_fire)    rsp_allow_o <= chk_allow_i;
        else if (timeout_hit) rsp_allow_o <= 1'b0;
    end

    // A clear in the same cycle as a new error lets the new error through.
    assign err_capture = chk_fire && chk_err_i.error_detected &&
                         (!err_o.error_detected || err_clear_i);

    // First-error latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          err_o <= '0;
        else if (err_capture) err_o <= chk_err_i;
        else if (err_clear_i) err_o <= '0;
    end

endmodule
